key_bounce_gen: RTL and testbench



---
 rtl/key_bounce_gen.sv | 147 ++++++++++++++
 tb/tb_key_bounce_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_bounce_gen.sv
// Mechanical-key emulator: on a press request drives an active-low key line through
// a pseudo-random press bounce, a stable hold and a pseudo-random release bounce.
module key_bounce_gen #(
    parameter int          BOUNCE_TOTAL = 250_000,
    parameter int          HOLD_CYC     = 1_000_000,
    parameter int          SEG_W        = 12,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       press,
    output logic       key,
    output logic       busy,
    output logic       done,
    output logic [7:0] toggle_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRESS = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_REL   = 2'd3;

    localparam int PH_MAX = (BOUNCE_TOTAL > HOLD_CYC) ? BOUNCE_TOTAL : HOLD_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0] BOUNCE_LAST = PH_W'(BOUNCE_TOTAL - 1);
    localparam logic [PH_W-1:0] HOLD_LAST   = PH_W'(HOLD_CYC - 1);
    localparam logic [15:0]     LFSR_INIT   = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    logic [1:0]       state_q, state_d;
    logic             key_q, key_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [15:0]      lfsr_next;
    logic             seg_load;
    logic             cnt_inc;
    logic             force_val;

    // x^16+x^14+x^13+x^11+1, Fibonacci form shifting toward the MSB
    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign force_val = (state_q == S_REL);

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        seg_d    = seg_q;
        lfsr_d   = lfsr_q;
        seg_load = 1'b0;
        cnt_inc  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (press) begin
                    key_d    = 1'b0;
                    busy_d   = 1'b1;
                    cnt_d    = 8'd0;
                    phase_d  = '0;
                    seg_load = 1'b1;
                    state_d  = S_PRESS;
                end
            end
            S_PRESS, S_REL: begin
                phase_d = phase_q + PH_W'(1);
                seg_d   = seg_q - SEG_W'(1);
                // Phase end takes priority over a segment expiry in the same cycle
                if (phase_q == BOUNCE_LAST) begin
                    key_d   = force_val;
                    cnt_inc = (key_q != force_val);
                    phase_d = '0;
                    if (state_q == S_REL) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else if (seg_q == '0) begin
                    key_d    = ~key_q;
                    cnt_inc  = 1'b1;
                    seg_load = 1'b1;
                end
            end
            S_HOLD: begin
                phase_d = phase_q + PH_W'(1);
                if (phase_q == HOLD_LAST) begin
                    key_d    = 1'b1;
                    cnt_inc  = 1'b1;
                    phase_d  = '0;
                    seg_load = 1'b1;
                    state_d  = S_REL;
                end
            end
            default: begin
                key_d   = 1'b1;
                busy_d  = 1'b0;
                phase_d = '0;
                state_d = S_IDLE;
            end
        endcase

        // Segment counter holds length-1 so expiry is a compare against zero
        if (seg_load) begin
            seg_d  = lfsr_q[SEG_W-1:0];
            lfsr_d = lfsr_next;
        end

        if (cnt_inc && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            key_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= 8'd0;
            phase_q <= '0;
            seg_q   <= '0;
            lfsr_q  <= LFSR_INIT;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign key        = key_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Bench for key_bounce_gen: an operation-level model builds each expected key waveform
// from toggle times, and every cycle's outputs are compared against it.
module tb_key_bounce_gen;

    localparam int          BT   = 20;
    localparam int          HC   = 50;
    localparam int          SW   = 3;
    localparam int          TOT  = 2 * BT + HC;
    localparam int          CAPN = 99;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       press = 1'b1;
    logic       key;
    logic       busy;
    logic       done;
    logic [7:0] toggle_cnt;

    int checks = 0;
    int errors = 0;

    key_bounce_gen #(
        .BOUNCE_TOTAL(BT),
        .HOLD_CYC    (HC),
        .SEG_W       (SW),
        .SEED        (SEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .press     (press),
        .key       (key),
        .busy      (busy),
        .done      (done),
        .toggle_cnt(toggle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        s_rst   = 1'b0;
    logic        s_press = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] m_lfsr  = SEED;
    int          m_k     = 0;
    bit          m_active = 1'b0;
    logic        m_key   = 1'b1;
    logic        m_busy  = 1'b0;
    logic        m_done  = 1'b0;
    logic [7:0]  m_cnt   = 8'd0;
    logic        wk[0:TOT];
    logic [7:0]  wc[0:TOT];

    always @(posedge clk) begin
        s_rst   <= rst_n;
        s_press <= press;
        s_valid <= 1'b1;
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic int next_seg();
        int l;
        l = (int'(m_lfsr) % (1 << SW)) + 1;
        m_lfsr = lfsr_step(m_lfsr);
        return l;
    endfunction

    // Expected waveform of one operation, indexed by edges after the accepting edge
    function automatic void build_op();
        int   nt;
        int   c;
        logic kv;
        kv = 1'b0;
        c = 0;
        wk[0] = 1'b0;
        wc[0] = 8'd0;
        nt = next_seg();
        for (int t = 1; t <= TOT; t++) begin
            if (t == BT || t == TOT) begin
                if (kv != (t == TOT)) begin
                    kv = (t == TOT);
                    c++;
                end
            end else if (t == BT + HC) begin
                kv = 1'b1;
                c++;
                nt = t + next_seg();
            end else if ((t < BT || t > BT + HC) && t == nt) begin
                kv = ~kv;
                c++;
                nt = t + next_seg();
            end
            wk[t] = kv;
            wc[t] = (c > 255) ? 8'd255 : 8'(c);
        end
    endfunction

    always @(negedge clk) begin
        if (s_valid) begin
            if (!s_rst) begin
                m_lfsr = SEED;
                m_active = 1'b0;
                m_key = 1'b1;
                m_busy = 1'b0;
                m_done = 1'b0;
                m_cnt = 8'd0;
            end else if (!m_busy && s_press) begin
                build_op();
                m_k = 0;
                m_active = 1'b1;
            end else if (m_active) begin
                m_k++;
                if (m_k == TOT) m_active = 1'b0;
            end else begin
                m_done = 1'b0;
            end
            if (s_rst && (m_active || m_k == TOT) && (m_busy || m_active || m_done || m_k == TOT)) begin
                if (m_active || m_busy) begin
                    m_key  = wk[m_k];
                    m_cnt  = wc[m_k];
                    m_busy = (m_k < TOT);
                    m_done = (m_k == TOT);
                end
            end
            chk("key", 16'(key), 16'(m_key));
            chk("busy", 16'(busy), 16'(m_busy));
            chk("done", 16'(done), 16'(m_done));
            chk("toggle_cnt", 16'(toggle_cnt), 16'(m_cnt));
        end
    end

    // ---------------- capture and drivers ----------------
    logic       cap_key [0:CAPN];
    logic       cap_busy[0:CAPN];
    logic       cap_done[0:CAPN];
    logic [7:0] cap_cnt [0:CAPN];
    logic       gold_key[0:CAPN];
    logic [7:0] gold_cnt[0:CAPN];
    logic       bb_key  [0:199];
    logic       bb_busy [0:199];
    logic       bb_done [0:199];

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        press = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Press at edge N, extra press pulses at N+p*, reset asserted at edges N+r, N+r+1
    task automatic capture(input int p1, input int p2, input int p3, input int r);
        @(negedge clk);
        press = 1'b1;
        for (int k = 0; k <= CAPN; k++) begin
            @(negedge clk);
            cap_key[k]  = key;
            cap_busy[k] = busy;
            cap_done[k] = done;
            cap_cnt[k]  = toggle_cnt;
            press = (k + 1 == p1) || (k + 1 == p2) || (k + 1 == p3);
            rst_n = !((k + 1 == r) || (k + 1 == r + 1));
        end
        press = 1'b0;
        rst_n = 1'b1;
    endtask

    function automatic int diff_vs_gold();
        int d;
        d = 0;
        for (int k = 0; k <= CAPN; k++)
            if (cap_key[k] !== gold_key[k] || cap_cnt[k] !== gold_cnt[k]) d++;
        return d;
    endfunction

    initial begin
        int n;
        int last_t;
        int bad_gap;

        // Reset held with press high: nothing may start
        repeat (5) begin
            @(negedge clk);
            chk("rst_key", 16'(key), 16'd1);
            chk("rst_busy", 16'(busy), 16'd0);
            chk("rst_done", 16'(done), 16'd0);
            chk("rst_cnt", 16'(toggle_cnt), 16'd0);
        end
        press = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 16'(busy), 16'd0);
        chk("model_lfsr_pin", lfsr_step(16'hACE1), 16'h59C3);

        // Single press golden capture
        capture(-10, -10, -10, -10);
        for (int k = 0; k <= CAPN; k++) begin
            gold_key[k] = cap_key[k];
            gold_cnt[k] = cap_cnt[k];
        end
        chk("k0", 16'(cap_key[0]), 16'd0);
        chk("k1", 16'(cap_key[1]), 16'd0);
        chk("k2", 16'(cap_key[2]), 16'd1);
        chk("k5", 16'(cap_key[5]), 16'd1);
        chk("k6", 16'(cap_key[6]), 16'd0);
        chk("k13", 16'(cap_key[13]), 16'd0);
        chk("k14", 16'(cap_key[14]), 16'd1);
        chk("k19", 16'(cap_key[19]), 16'd1);
        chk("cnt14", 16'(cap_cnt[14]), 16'd3);
        chk("cnt20", 16'(cap_cnt[20]), 16'd4);
        n = 0;
        for (int k = BT; k < BT + HC; k++) if (cap_key[k] !== 1'b0) n++;
        chk("hold_low", 16'(n), 16'd0);
        n = 0;
        for (int k = TOT; k <= CAPN; k++) if (cap_key[k] !== 1'b1) n++;
        chk("idle_high_after", 16'(n), 16'd0);
        n = 0;
        for (int k = 0; k <= CAPN; k++) if (cap_busy[k] === 1'b1) n++;
        chk("busy_cycles", 16'(n), 16'(TOT));
        chk("busy_last", 16'(cap_busy[TOT-1]), 16'd1);
        n = 0;
        for (int k = 0; k <= CAPN; k++) if (cap_done[k] === 1'b1) n++;
        chk("done_count", 16'(n), 16'd1);
        chk("done_at_90", 16'(cap_done[TOT]), 16'd1);
        n = 0;
        for (int k = 1; k <= TOT; k++) if (cap_key[k] !== cap_key[k-1]) n++;
        chk("edges_vs_cnt", 16'(cap_cnt[TOT]), 16'(n));
        bad_gap = 0;
        last_t = 0;
        for (int k = 1; k < BT; k++) begin
            if (cap_key[k] !== cap_key[k-1]) begin
                if (k - last_t < 1 || k - last_t > (1 << SW)) bad_gap++;
                last_t = k;
            end
        end
        last_t = BT + HC;
        for (int k = BT + HC + 1; k < TOT; k++) begin
            if (cap_key[k] !== cap_key[k-1]) begin
                if (k - last_t < 1 || k - last_t > (1 << SW)) bad_gap++;
                last_t = k;
            end
        end
        chk("segment_range", 16'(bad_gap), 16'd0);

        // Presses during busy are ignored
        do_reset();
        capture(5, 40, 80, -10);
        chk("repeat_press_wave", 16'(diff_vs_gold()), 16'd0);

        // Reset in HOLD aborts, then a fresh press replays the golden waveform
        do_reset();
        capture(-10, -10, -10, 30);
        chk("abort_key", 16'(cap_key[30]), 16'd1);
        chk("abort_busy", 16'(cap_busy[30]), 16'd0);
        chk("abort_cnt", 16'(cap_cnt[30]), 16'd0);
        repeat (2) @(negedge clk);
        capture(-10, -10, -10, -10);
        chk("reseed_wave", 16'(diff_vs_gold()), 16'd0);

        // Back-to-back operations with press held high
        do_reset();
        @(negedge clk);
        press = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            bb_key[k]  = key;
            bb_busy[k] = busy;
            bb_done[k] = done;
        end
        press = 1'b0;
        chk("bb_done1", 16'(bb_done[TOT]), 16'd1);
        chk("bb_gap_busy", 16'(bb_busy[TOT]), 16'd0);
        chk("bb_restart", 16'(bb_busy[TOT+1]), 16'd1);
        chk("bb_restart_key", 16'(bb_key[TOT+1]), 16'd0);
        chk("bb_done2", 16'(bb_done[2*TOT+1]), 16'd1);
        n = 0;
        for (int k = 0; k <= TOT; k++) if (bb_key[k] !== gold_key[k]) n++;
        chk("bb_first_eq_gold", 16'(n), 16'd0);
        n = 0;
        for (int k = 0; k <= TOT; k++) if (bb_key[TOT+1+k] !== gold_key[k]) n++;
        chk("bb_second_differs", 16'(n != 0), 16'd1);

        // Random presses and occasional resets, checked every cycle by the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            press = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 399) != 0);
        end
        press = 1'b0;
        rst_n = 1'b1;
        repeat (TOT + 5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
